// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: runs 32-bit ADD/SUB and 16x16 MUL over a shared 16-bit alu.
// Define ALU_SEQ_DIV_EN to enable the 16-cycle restoring DIV16; otherwise DIV16 returns zero.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_logic_func,
  output logic [15:0] alu_ina,
  output logic [15:0] alu_inb,
  output logic [15:0] alu_inc,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_cout
);

  // state | meaning
  // IDLE  | ready for a command
  // RUN   | driving the alu, cnt_q cycles remain after this one
  // DONE  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_MUL = 2'b10;
  localparam logic [1:0] CMD_DIV = 2'b11;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h2;

  state_t      state, state_next;
  logic [3:0]  cnt_q;
  logic [1:0]  cmd_q;
  logic [31:0] a_q, b_q;
  logic [15:0] hi_q, lo_q;
  logic        carry_q;
  logic        first_cyc;

  // hi_q/lo_q hold: ADD/SUB result halves, MUL {H,L}, DIV {R,Q}
  assign first_cyc      = (cnt_q == 4'd1);
  assign rsp_result     = {hi_q, lo_q};
  assign rsp_carry      = carry_q;
  assign alu_logic_func = 4'h0;
  assign alu_inc        = 16'h0;

`ifdef ALU_SEQ_DIV_EN
  logic [15:0] div_trial;
  logic        div_accept;
  assign div_trial  = {hi_q[14:0], lo_q[15]};
  assign div_accept = hi_q[15] | alu_cout;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_op     = OP_ADD;
    alu_ina    = 16'h0;
    alu_inb    = 16'h0;
    alu_cin    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt_q == 4'd0) state_next = DONE;
        case (cmd_q)
          CMD_ADD, CMD_SUB: begin
            alu_op = (cmd_q == CMD_SUB) ? OP_SUB : OP_ADD;
            if (first_cyc) begin
              alu_ina = a_q[15:0];
              alu_inb = b_q[15:0];
              alu_cin = (cmd_q == CMD_SUB);
            end else begin
              alu_ina = a_q[31:16];
              alu_inb = b_q[31:16];
              alu_cin = carry_q;
            end
          end
          CMD_MUL: begin
            alu_ina = hi_q;
            alu_inb = lo_q[0] ? a_q[15:0] : 16'h0;
          end
          default: begin
`ifdef ALU_SEQ_DIV_EN
            alu_op  = OP_SUB;
            alu_ina = div_trial;
            alu_inb = b_q[15:0];
            alu_cin = 1'b1;
`endif
          end
        endcase
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      cmd_q   <= CMD_ADD;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      hi_q    <= 16'h0;
      lo_q    <= 16'h0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q   <= req_cmd;
            a_q     <= req_a;
            b_q     <= req_b;
            hi_q    <= 16'h0;
            carry_q <= 1'b0;
            case (req_cmd)
              CMD_MUL: begin
                lo_q  <= req_b[15:0];
                cnt_q <= 4'd15;
              end
              CMD_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                lo_q  <= req_a[15:0];
                cnt_q <= 4'd15;
`else
                lo_q  <= 16'h0;
                cnt_q <= 4'd0;
`endif
              end
              default: begin
                lo_q  <= 16'h0;
                cnt_q <= 4'd1;
              end
            endcase
          end
        end
        RUN: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          case (cmd_q)
            CMD_ADD, CMD_SUB: begin
              if (first_cyc) lo_q <= alu_out;
              else           hi_q <= alu_out;
              carry_q <= alu_cout;
            end
            CMD_MUL: begin
              hi_q <= {alu_cout, alu_out[15:1]};
              lo_q <= {alu_out[0], lo_q[15:1]};
            end
            default: begin
`ifdef ALU_SEQ_DIV_EN
              hi_q <= div_accept ? alu_out : div_trial;
              lo_q <= {lo_q[14:0], div_accept};
`endif
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural model of the 16-bit alu.
// Honours ALU_SEQ_DIV_EN to select the expected DIV16 behaviour.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic [3:0]  alu_op, alu_logic_func;
  logic [15:0] alu_ina, alu_inb, alu_inc;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_op(alu_op), .alu_logic_func(alu_logic_func),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_inc(alu_inc), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // alu model: op 0 = ina+inb+cin, op 2 = ina+~inb+cin (cout = no borrow)
  always_comb begin
    logic [16:0] sum;
    sum = 17'h0;
    case (alu_op)
      4'h0: sum = {1'b0, alu_ina} + {1'b0, alu_inb} + {16'h0, alu_cin};
      4'h2: sum = {1'b0, alu_ina} + {1'b0, ~alu_inb} + {16'h0, alu_cin};
      default: sum = 17'h0;
    endcase
    {alu_cout, alu_out} = sum;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  // issue one command, check first-cycle alu op, latency, result, carry, and return to idle
  task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] exp_op, input int exp_lat,
                         input logic [31:0] exp_res, input logic exp_carry);
    chk({tag, "_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0;
    chk({tag, "_op"}, alu_op, exp_op);
    wait_rsp(tag, exp_lat);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_carry"}, rsp_carry, exp_carry);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'b00; req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 32'h0);
    chk("rst_carry", rsp_carry, 0);
    chk("rst_alu_op", alu_op, 4'h0);
    chk("rst_alu_ina", alu_ina, 16'h0);
    chk("rst_alu_inb", alu_inb, 16'h0);
    chk("rst_alu_cin", alu_cin, 0);
    chk("rst_logic_func", alu_logic_func, 4'h0);
    chk("rst_inc", alu_inc, 16'h0);
    rst = 1'b0;
    tick();

    run_cmd("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 2, 32'h0000_0000, 1'b1);
    run_cmd("add_mid",  2'b00, 32'h1234_5678, 32'h0000_FFFF, 4'h0, 2, 32'h1235_5677, 1'b0);
    run_cmd("sub_neg",  2'b01, 32'h0000_0000, 32'h0000_0001, 4'h2, 2, 32'hFFFF_FFFF, 1'b0);
    run_cmd("sub_brw",  2'b01, 32'h0001_0000, 32'h0000_0001, 4'h2, 2, 32'h0000_FFFF, 1'b1);
    run_cmd("mul_max",  2'b10, 32'h0000_FFFF, 32'h0000_FFFF, 4'h0, 16, 32'hFFFE_0001, 1'b0);
    run_cmd("mul_zero", 2'b10, 32'h0000_0000, 32'h0000_1234, 4'h0, 16, 32'h0000_0000, 1'b0);
    run_cmd("mul_upper", 2'b10, 32'hABCD_0003, 32'h1234_0005, 4'h0, 16, 32'h0000_000F, 1'b0);
    run_cmd("mul_shift", 2'b10, 32'h0000_1234, 32'h0000_0010, 4'h0, 16, 32'h0001_2340, 1'b0);
`ifdef ALU_SEQ_DIV_EN
    run_cmd("div_100_7", 2'b11, 32'h0000_0064, 32'h0000_0007, 4'h2, 16, 32'h0002_000E, 1'b0);
    run_cmd("div_by_0",  2'b11, 32'h0000_0005, 32'h0000_0000, 4'h2, 16, 32'h0005_FFFF, 1'b0);
`else
    run_cmd("div_off", 2'b11, 32'h0000_0064, 32'h0000_0007, 4'h0, 1, 32'h0000_0000, 1'b0);
`endif

    // backpressure: result held, second request ignored while busy
    req_valid = 1'b1; req_cmd = 2'b00; req_a = 32'h0001_FFFF; req_b = 32'h0002_0001;
    tick();
    req_cmd = 2'b10; req_a = 32'h0000_0002; req_b = 32'h0000_0003;
    wait_rsp("bp", 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 32'h0004_0000);
      chk("bp_carry", rsp_carry, 0);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("bp_released", rsp_valid, 0);
    tick();
    chk("bp_no_second", req_ready, 1);

    // reset in MUL RUN cycle 7 aborts without a response
    req_valid = 1'b1; req_cmd = 2'b10; req_a = 32'h0000_FFFF; req_b = 32'h0000_FFFF;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    chk("abort_busy", req_ready, 0);
    rst = 1'b1;
    tick();
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_op", alu_op, 4'h0);
    chk("abort_result", rsp_result, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_rsp", rsp_valid, 0);
    run_cmd("add_after", 2'b00, 32'h8000_0001, 32'h8000_FFFF, 4'h0, 2, 32'h0001_0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
